// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the decode stage.
//   alu_ctrl_t   4-bit ALU operation code handed to execute
//   OPC_*        RV32I/RV64I major opcodes recognised by the decoder
//   dec_entry_t  one decoded instruction (PC and immediate held at 64 bits;
//                the stage drives only the low XLEN bits)
//   st_e         occupancy states of the two-entry decode buffer
// Optional feature macro (consumed elsewhere): DECODE_ILLEGAL_CHECK_EN.
package decode_pkg;

  localparam int XLEN_MAX = 64;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_SUB   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_XOR   = 4'b0110,
    ALU_SLTU  = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_JALR  = 4'b1010,
    ALU_JAL   = 4'b1011,
    ALU_STORE = 4'b1100,
    ALU_LOAD  = 4'b1101,
    ALU_AUIPC = 4'b1110,
    ALU_NONE  = 4'b1111
  } alu_ctrl_t;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                rd_we;
    logic [2:0]          funct3;
    logic [XLEN_MAX-1:0] imm;
    alu_ctrl_t           alu;
    logic                illegal;
  } dec_entry_t;

  localparam dec_entry_t NOP_ENTRY = '{
    pc: '0, rs1: '0, rs2: '0, rd: '0, rd_we: 1'b0, funct3: '0,
    imm: '0, alu: ALU_NONE, illegal: 1'b0
  };

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } st_e;

  // Register-register / register-immediate ALU op selected by funct3
  // (the funct7/inst[30] variants sub and sra are handled by the caller).
  function automatic alu_ctrl_t alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I/RV64I instruction decoder.
//   inst_i [31:0]    instruction word
//   pc_i   [XLEN-1:0] instruction address, copied into the entry
//   dec_o            decoded entry (dec_entry_t)
// Undecodable words come out as NOP_ENTRY. With DECODE_ILLEGAL_CHECK_EN
// defined they also carry illegal = 1, and for XLEN=32 a shift immediate
// with inst[25] set is rejected; otherwise illegal is tied to 0.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output dec_entry_t      dec_o
);

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [XLEN_MAX-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

  assign opc = inst_i[6:0];
  assign rd  = inst_i[11:7];
  assign f3  = inst_i[14:12];
  assign rs1 = inst_i[19:15];
  assign rs2 = inst_i[24:20];
  assign f7  = inst_i[31:25];

  assign imm_i = {{52{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{51{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                  inst_i[11:8], 1'b0};
  assign imm_u = {{32{inst_i[31]}}, inst_i[31:12], 12'h000};
  assign imm_j = {{43{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                  inst_i[30:21], 1'b0};
  // inst[25] is shamt[5] only on RV64
  assign shamt = (XLEN == 64) ? {58'd0, inst_i[25:20]} : {59'd0, inst_i[24:20]};

  dec_entry_t d;
  logic       bad, writes;

  always_comb begin
    d      = NOP_ENTRY;
    bad    = 1'b0;
    writes = 1'b0;
    case (opc)
      OPC_OP: begin
        d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.funct3 = f3; writes = 1'b1;
        if (f7 == 7'h00)                   d.alu = alu_from_f3(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) d.alu = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) d.alu = ALU_SRA;
        else                                bad   = 1'b1;
      end
      OPC_OP_IMM: begin
        d.rs1 = rs1; d.rd = rd; d.funct3 = f3; writes = 1'b1;
        d.imm = imm_i;
        d.alu = alu_from_f3(f3);
        if (f3 == 3'd1 || f3 == 3'd5) begin
          d.imm = shamt;
          if (f3 == 3'd5 && inst_i[30]) d.alu = ALU_SRA;
          if (inst_i[31] || inst_i[29:26] != 4'd0 || (f3 == 3'd1 && inst_i[30]))
            bad = 1'b1;
          if (CHECK_EN && XLEN == 32 && inst_i[25]) bad = 1'b1;
        end
      end
      OPC_LOAD: begin
        d.rs1 = rs1; d.rd = rd; d.funct3 = f3; d.imm = imm_i;
        d.alu = ALU_LOAD; writes = 1'b1;
        if (f3 == 3'd7 || ((f3 == 3'd3 || f3 == 3'd6) && XLEN == 32)) bad = 1'b1;
      end
      OPC_STORE: begin
        d.rs1 = rs1; d.rs2 = rs2; d.funct3 = f3; d.imm = imm_s;
        d.alu = ALU_STORE;
        if (f3[2] || (f3 == 3'd3 && XLEN == 32)) bad = 1'b1;
      end
      OPC_BRANCH: begin
        d.rs1 = rs1; d.rs2 = rs2; d.funct3 = f3; d.imm = imm_b;
        d.alu = ALU_NONE;
        if (f3 == 3'd2 || f3 == 3'd3) bad = 1'b1;
      end
      OPC_JAL: begin
        d.rd = rd; d.imm = imm_j; d.alu = ALU_JAL; writes = 1'b1;
      end
      OPC_JALR: begin
        d.rs1 = rs1; d.rd = rd; d.funct3 = f3; d.imm = imm_i;
        d.alu = ALU_JALR; writes = 1'b1;
        if (f3 != 3'd0) bad = 1'b1;
      end
      OPC_LUI: begin
        d.rd = rd; d.imm = imm_u; d.alu = ALU_ADD; writes = 1'b1;
      end
      OPC_AUIPC: begin
        d.rd = rd; d.imm = imm_u; d.alu = ALU_AUIPC; writes = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    d.rd_we = writes && (d.rd != 5'd0);
    if (bad) d = NOP_ENTRY;
    d.illegal = CHECK_EN && bad;
    d.pc = '0;
    d.pc[XLEN-1:0] = pc_i;
  end

  assign dec_o = d;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked decode stage with a two-entry skid
// buffer between fetch (in_*) and execute (out_*).
//   clk_i, rst_i (sync, active high), flush_i (drops entries + input beat)
//   in_valid_i / in_ready_o, in_inst_i [31:0], in_pc_i [XLEN-1:0]
//   out_valid_o / out_ready_i, out_pc_o, out_rs1_o/out_rs2_o/out_rd_o [4:0],
//   out_rd_we_o, out_funct3_o [2:0], out_imm_o [XLEN-1:0],
//   out_alu_ctrl_o [3:0], out_illegal_o
// Optional feature: DECODE_ILLEGAL_CHECK_EN (illegal-word flagging, inside
// decode_comb).
//
// state    | meaning
// ST_EMPTY | no entries held
// ST_ONE   | head valid, skid empty
// ST_FULL  | head and skid valid, input stalled
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_inst_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [4:0]      out_rs1_o,
  output logic [4:0]      out_rs2_o,
  output logic [4:0]      out_rd_o,
  output logic            out_rd_we_o,
  output logic [2:0]      out_funct3_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic [3:0]      out_alu_ctrl_o,
  output logic            out_illegal_o
);

  st_e        state_q, state_d;
  dec_entry_t head_q, skid_q, dec;
  logic       accept, pop;

  decode_comb #(.XLEN(XLEN)) u_decode_comb (
    .inst_i (in_inst_i),
    .pc_i   (in_pc_i),
    .dec_o  (dec)
  );

  // in_ready depends only on the state register, never on out_ready
  assign accept = in_valid_i && in_ready_o && !flush_i;
  assign pop    = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !pop)      state_d = ST_FULL;
          else if (pop && !accept) state_d = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = (state_q != ST_FULL);
    out_valid_o = (state_q != ST_EMPTY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q <= NOP_ENTRY;
      skid_q <= NOP_ENTRY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) head_q <= dec;
        ST_ONE: begin
          if (accept && pop) head_q <= dec;
          else if (accept)   skid_q <= dec;
        end
        ST_FULL:  if (pop) head_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign out_pc_o       = head_q.pc[XLEN-1:0];
  assign out_rs1_o      = head_q.rs1;
  assign out_rs2_o      = head_q.rs2;
  assign out_rd_o       = head_q.rd;
  assign out_rd_we_o    = head_q.rd_we;
  assign out_funct3_o   = head_q.funct3;
  assign out_imm_o      = head_q.imm[XLEN-1:0];
  assign out_alu_ctrl_o = head_q.alu;
  assign out_illegal_o  = head_q.illegal;

  // upper PC/immediate bits are unused when XLEN=32
  logic unused_head;
  assign unused_head = ^head_q;

endmodule
